vol_btn_ctrl: RTL

VOL_BTN_CTRL -- requirements
Module: vol_btn_ctrl

---
 rtl/digiav_ctrl_pkg.sv | 23 ++
 rtl/vol_req_hs.sv | 39 +++
 rtl/vol_btn_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/digiav_ctrl_pkg.sv
// Shared definitions for the DigiAV control blocks: volume-button FSM
// encoding, default timing constants and timer sizing helper.
package digiav_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2,
      BOTH   = 2'd3
   } btn_state_e;

   // 0.5 s hold and 0.1 s repeat at the 40 MHz system clock
   localparam int unsigned DEF_HOLD_CYCLES   = 32'd20000000;
   localparam int unsigned DEF_REPEAT_CYCLES = 32'd4000000;

   function automatic int unsigned tmr_width(input int unsigned hold_cycles,
                                             input int unsigned repeat_cycles);
      int unsigned span;
      span = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
      return (span < 32'd2) ? 32'd1 : $clog2(span);
   endfunction

endpackage

// File: rtl/vol_req_hs.sv
// Request/ack holding register: offers a frozen volume word to the consumer
// and reloads it from the live level only when no request is pending.
module vol_req_hs #(
   parameter int unsigned VOL_W    = 5,
   parameter int unsigned VOL_INIT = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [VOL_W-1:0] i_vol,
   input  logic             i_ack,
   output logic [VOL_W-1:0] o_vol,
   output logic             o_req
);

   // Reset value differs from the initial level so a first request is forced
   localparam logic [VOL_W-1:0] VOL_RST = ~VOL_W'(VOL_INIT);

   logic [VOL_W-1:0] vol_r;
   logic             req_r;

   // Offer register: hold while pending, drop on ack, reload on any change
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vol_r <= VOL_RST;
         req_r <= 1'b0;
      end else if (req_r) begin
         if (i_ack) begin
            req_r <= 1'b0;
         end
      end else if (i_vol != vol_r) begin
         vol_r <= i_vol;
         req_r <= 1'b1;
      end
   end

   assign o_vol = vol_r;
   assign o_req = req_r;

endmodule

// File: rtl/vol_btn_ctrl.sv
// Volume button controller: single step on press, auto-repeat after a hold,
// saturating level, handed to the consumer through a request/ack register.
module vol_btn_ctrl
   import digiav_ctrl_pkg::*;
#(
   parameter int unsigned VOL_W         = 5,
   parameter int unsigned VOL_MAX       = 31,
   parameter int unsigned VOL_INIT      = 20,
   parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_btn_minus,
   input  logic             i_btn_plus,
   output logic [VOL_W-1:0] o_vol,
   output logic             o_req,
   input  logic             i_ack,
   output logic             o_busy
);

   localparam int unsigned      TMR_W       = tmr_width(HOLD_CYCLES, REPEAT_CYCLES);
   localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 32'd1);
   localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 32'd1);
   localparam logic [TMR_W-1:0] TMR_ZERO    = TMR_W'(32'd0);
   localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(32'd1);
   localparam logic [VOL_W-1:0] VOL_TOP     = VOL_W'(VOL_MAX);
   localparam logic [VOL_W-1:0] VOL_RST     = VOL_W'(VOL_INIT);
   localparam logic [VOL_W-1:0] VOL_ZERO    = VOL_W'(32'd0);
   localparam logic [VOL_W-1:0] VOL_ONE     = VOL_W'(32'd1);

   btn_state_e       state_r, state_s;
   logic [TMR_W-1:0] timer_r, timer_s;
   logic [VOL_W-1:0] vol_q_r, vol_q_s;
   logic             dir_up_r, dir_up_s;
   logic             btn_minus_r, btn_plus_r;
   logic             minus_s, plus_s, both_s, active_s;
   logic             step_s, step_up_s;
   logic             req_s;

   // Button input register plus FSM, timer, direction and level state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         btn_minus_r <= 1'b1;
         btn_plus_r  <= 1'b1;
         state_r     <= IDLE;
         timer_r     <= TMR_ZERO;
         vol_q_r     <= VOL_RST;
         dir_up_r    <= 1'b0;
      end else begin
         btn_minus_r <= i_btn_minus;
         btn_plus_r  <= i_btn_plus;
         state_r     <= state_s;
         timer_r     <= timer_s;
         vol_q_r     <= vol_q_s;
         dir_up_r    <= dir_up_s;
      end
   end

   // Next-state, timer and step decision
   always_comb begin
      minus_s   = ~btn_minus_r;
      plus_s    = ~btn_plus_r;
      both_s    = minus_s & plus_s;
      active_s  = dir_up_r ? plus_s : minus_s;
      state_s   = state_r;
      timer_s   = timer_r;
      dir_up_s  = dir_up_r;
      step_s    = 1'b0;
      step_up_s = dir_up_r;
      case (state_r)
         IDLE: begin
            timer_s = TMR_ZERO;
            if (both_s) begin
               state_s = BOTH;
            end else if (plus_s | minus_s) begin
               state_s   = HOLD;
               dir_up_s  = plus_s;
               step_s    = 1'b1;
               step_up_s = plus_s;
            end else begin
               state_s = IDLE;
            end
         end
         HOLD, REPEAT: begin
            if (both_s) begin
               state_s = BOTH;
               timer_s = TMR_ZERO;
            end else if (!active_s) begin
               state_s = IDLE;
               timer_s = TMR_ZERO;
            end else if (timer_r == ((state_r == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
               state_s = REPEAT;
               timer_s = TMR_ZERO;
               step_s  = 1'b1;
            end else begin
               timer_s = timer_r + TMR_ONE;
            end
         end
         BOTH: begin
            timer_s = TMR_ZERO;
            if (!plus_s && !minus_s) begin
               state_s = IDLE;
            end else begin
               state_s = BOTH;
            end
         end
         default: begin
            state_s = IDLE;
            timer_s = TMR_ZERO;
         end
      endcase
   end

   // Saturating level update
   always_comb begin
      vol_q_s = vol_q_r;
      if (step_s && step_up_s && (vol_q_r != VOL_TOP)) begin
         vol_q_s = vol_q_r + VOL_ONE;
      end else if (step_s && !step_up_s && (vol_q_r != VOL_ZERO)) begin
         vol_q_s = vol_q_r - VOL_ONE;
      end else begin
         vol_q_s = vol_q_r;
      end
   end

   vol_req_hs #(
      .VOL_W    (VOL_W),
      .VOL_INIT (VOL_INIT)
   ) u_req_hs (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_vol (vol_q_r),
      .i_ack (i_ack),
      .o_vol (o_vol),
      .o_req (req_s)
   );

   assign o_req  = req_s;
   assign o_busy = (state_r != IDLE) | req_s;

endmodule
